// File: rtl/i2c_ball_slave.sv
// Write-only I2C slave that collects a fixed-size ball-state packet and
// publishes it atomically on STOP, so a partial packet is never visible.
module i2c_ball_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h12,
  parameter int         NUM_BYTES  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] y_pos0,
  output logic [7:0] y_pos1,
  output logic [7:0] y_vel,
  output logic [7:0] gravity,
  output logic [7:0] ball_speed,
  output logic       data_valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    WAIT_STOP
  } state_t;

  localparam logic [2:0] NumBytesC = 3'(NUM_BYTES);
  localparam logic [3:0] BitsPerByte = 4'd8;

  logic       sclMeta_q, sclSync_q, sclPrev_q;
  logic       sdaMeta_q, sdaSync_q, sdaPrev_q;
  logic       sclRise, sclFall, startDet, stopDet;

  state_t     state_q;
  logic [3:0] bitCnt_q;
  logic [2:0] byteCnt_q;
  logic       overflow_q;
  logic [7:0] shift_q, shift_d;
  logic [7:0] shadow_q [NUM_BYTES];
  logic [7:0] pkt_q    [NUM_BYTES];
  logic       sdaOe_q, dataValid_q, busy_q;

  // Two-flop synchronizers plus one history flop for edge detection;
  // all reset to 1 so an idle bus produces no spurious edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclMeta_q <= 1'b1;
      sclSync_q <= 1'b1;
      sclPrev_q <= 1'b1;
      sdaMeta_q <= 1'b1;
      sdaSync_q <= 1'b1;
      sdaPrev_q <= 1'b1;
    end else begin
      sclMeta_q <= scl;
      sclSync_q <= sclMeta_q;
      sclPrev_q <= sclSync_q;
      sdaMeta_q <= sda_i;
      sdaSync_q <= sdaMeta_q;
      sdaPrev_q <= sdaSync_q;
    end
  end

  assign sclRise  = sclSync_q & ~sclPrev_q;
  assign sclFall  = ~sclSync_q & sclPrev_q;
  assign startDet = sdaPrev_q & ~sdaSync_q & sclSync_q;
  assign stopDet  = ~sdaPrev_q & sdaSync_q & sclSync_q;
  assign shift_d  = {shift_q[6:0], sdaSync_q};

  // Protocol FSM; START has priority over STOP, and bus conditions
  // override whatever bit-level activity the current state expects.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bitCnt_q    <= '0;
      byteCnt_q   <= '0;
      overflow_q  <= 1'b0;
      shift_q     <= '0;
      sdaOe_q     <= 1'b0;
      dataValid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < NUM_BYTES; i++) begin
        shadow_q[i] <= '0;
        pkt_q[i]    <= '0;
      end
    end else begin
      dataValid_q <= 1'b0;
      if (startDet) begin
        state_q    <= ADDR;
        bitCnt_q   <= '0;
        byteCnt_q  <= '0;
        overflow_q <= 1'b0;
        sdaOe_q    <= 1'b0;
        busy_q     <= 1'b1;
        for (int i = 0; i < NUM_BYTES; i++) begin
          shadow_q[i] <= '0;
        end
      end else if (stopDet) begin
        if ((state_q == DATA || state_q == DATA_ACK) &&
            byteCnt_q == NumBytesC && !overflow_q) begin
          for (int i = 0; i < NUM_BYTES; i++) begin
            pkt_q[i] <= shadow_q[i];
          end
          dataValid_q <= 1'b1;
        end
        state_q  <= IDLE;
        bitCnt_q <= '0;
        sdaOe_q  <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          ADDR, DATA: begin
            if (sclRise && bitCnt_q != BitsPerByte) begin
              shift_q  <= shift_d;
              bitCnt_q <= bitCnt_q + 4'd1;
            end else if (sclFall && bitCnt_q == BitsPerByte) begin
              bitCnt_q <= '0;
              if (state_q == ADDR) begin
                if (shift_q[7:1] == SLAVE_ADDR && !shift_q[0]) begin
                  sdaOe_q <= 1'b1;
                  state_q <= ADDR_ACK;
                end else begin
                  state_q <= WAIT_STOP;
                end
              end else if (byteCnt_q < NumBytesC) begin
                shadow_q[byteCnt_q] <= shift_q;
                byteCnt_q           <= byteCnt_q + 3'd1;
                sdaOe_q             <= 1'b1;
                state_q             <= DATA_ACK;
              end else begin
                overflow_q <= 1'b1;
                state_q    <= WAIT_STOP;
              end
            end
          end
          // ACK is held through the ninth clock pulse.
          ADDR_ACK, DATA_ACK: begin
            if (sclFall) begin
              sdaOe_q <= 1'b0;
              state_q <= DATA;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign sda_oe     = sdaOe_q;
  assign data_valid = dataValid_q;
  assign busy       = busy_q;
  assign y_pos0     = pkt_q[0];
  assign y_pos1     = pkt_q[1];
  assign y_vel      = pkt_q[2];
  assign gravity    = pkt_q[3];
  assign ball_speed = pkt_q[4];

endmodule

// File: tb/tb_i2c_ball_slave.sv
// Bit-banged I2C master driving i2c_ball_slave, checked against a
// packet-level model of which bytes are ACKed and which packets commit.
module tb_i2c_ball_slave;

  localparam int Q = 4;
  localparam logic [6:0] Addr = 7'h12;

  logic        clk = 1'b0;
  logic        reset;
  logic        scl;
  logic        sdaDrv;
  logic        sdaLine;
  logic        sda_oe;
  logic [7:0]  y_pos0, y_pos1, y_vel, gravity, ball_speed;
  logic        data_valid;
  logic        busy;
  logic [39:0] outBus;

  assign sdaLine = sdaDrv & ~sda_oe;
  assign outBus  = {y_pos0, y_pos1, y_vel, gravity, ball_speed};

  i2c_ball_slave #(.SLAVE_ADDR(Addr), .NUM_BYTES(5)) dut (
    .clk(clk), .reset(reset), .scl(scl), .sda_i(sdaLine), .sda_oe(sda_oe),
    .y_pos0(y_pos0), .y_pos1(y_pos1), .y_vel(y_vel), .gravity(gravity),
    .ball_speed(ball_speed), .data_valid(data_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int testsRun = 0;
  int testsFailed = 0;
  int cycle = 0;
  int dvCount = 0;
  int dvCycle = 0;
  int dvBefore = 0;
  int stopCycle = 0;
  int stabilityErrors = 0;
  bit oeSeen = 0;
  bit resetAtEdge = 1;
  logic [39:0] prevOut = '0;

  logic [7:0]  txQ[$];
  bit          ackQ[$];
  bit          expAckQ[$];
  bit          expCommit;
  logic [39:0] expBus = '0;
  logic        busyAfterStart, busyAfterStop;

  // Cycle counter and reset history, taken on the active edge.
  always @(posedge clk) begin
    cycle++;
    resetAtEdge = reset;
  end

  // Observe the DUT between active edges: pulse counting, ACK activity and
  // the rule that outputs move only together with data_valid or reset.
  always @(negedge clk) begin
    if (data_valid) begin
      dvCount++;
      dvCycle = cycle;
    end
    if (sda_oe) oeSeen = 1;
    if (!data_valid && !resetAtEdge && outBus !== prevOut) stabilityErrors++;
    prevOut = outBus;
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic waitQ();
    repeat (Q) @(negedge clk);
  endtask

  task automatic busStart();
    sdaDrv = 1'b1; waitQ();
    scl = 1'b1;    waitQ();
    sdaDrv = 1'b0; waitQ();
    scl = 1'b0;    waitQ();
  endtask

  task automatic busStop();
    sdaDrv = 1'b0; waitQ();
    scl = 1'b1;    waitQ();
    sdaDrv = 1'b1;
    stopCycle = cycle;
    waitQ();
  endtask

  task automatic busWrite(input logic [7:0] b, output bit ack);
    for (int i = 7; i >= 0; i--) begin
      sdaDrv = b[i]; waitQ();
      scl = 1'b1;    waitQ(); waitQ();
      scl = 1'b0;    waitQ();
    end
    sdaDrv = 1'b1; waitQ();
    scl = 1'b1;    waitQ();
    ack = !sdaLine;
    waitQ();
    scl = 1'b0;    waitQ();
  endtask

  // Runs one segment: START, every byte in txQ (address first), optional STOP.
  task automatic applyStimulus(input bit withStop);
    bit ack;
    ackQ.delete();
    oeSeen = 0;
    dvBefore = dvCount;
    busStart();
    busyAfterStart = busy;
    foreach (txQ[i]) begin
      busWrite(txQ[i], ack);
      ackQ.push_back(ack);
    end
    if (withStop) begin
      busStop();
      waitQ();
      busyAfterStop = busy;
    end
  endtask

  // Packet-level rules: the address byte is ACKed when it names us for a
  // write, the first five data bytes are then ACKed, and only exactly five
  // bytes closed by STOP replace the published packet.
  task automatic modelPacket(input bit withStop);
    logic [7:0] a;
    bit addressed;
    int n;
    a = txQ[0];
    addressed = (a[7:1] == Addr) && !a[0];
    n = txQ.size() - 1;
    expAckQ.delete();
    expAckQ.push_back(addressed);
    for (int i = 1; i <= n; i++) expAckQ.push_back(addressed && i <= 5);
    expCommit = withStop && addressed && n == 5;
    if (expCommit) expBus = {txQ[1], txQ[2], txQ[3], txQ[4], txQ[5]};
  endtask

  task automatic verifyPacket(input string tag, input bit withStop);
    bit anyAck = 0;
    modelPacket(withStop);
    checkOutput({tag, " ackcount"}, ackQ.size(), expAckQ.size());
    foreach (expAckQ[i]) begin
      if (i < ackQ.size())
        checkOutput($sformatf("%s ack%0d", tag, i), ackQ[i], expAckQ[i]);
      anyAck |= expAckQ[i];
    end
    checkOutput({tag, " oe"}, oeSeen, anyAck);
    checkOutput({tag, " dv"}, dvCount - dvBefore, expCommit ? 1 : 0);
    checkOutput({tag, " out"}, outBus, expBus);
    checkOutput({tag, " busyStart"}, busyAfterStart, 1'b1);
    if (withStop) checkOutput({tag, " busyStop"}, busyAfterStop, 1'b0);
    if (expCommit)
      checkOutput({tag, " latency"},
                  (dvCycle - stopCycle >= 1) && (dvCycle - stopCycle <= 4), 1'b1);
  endtask

  task automatic loadTx(input logic [7:0] a, input int n, input logic [7:0] base,
                        input bit rnd);
    txQ.delete();
    txQ.push_back(a);
    for (int i = 0; i < n; i++)
      txQ.push_back(rnd ? 8'($urandom) : 8'(base + 8'(i)));
  endtask

  initial begin
    bit ack;
    logic [7:0] a;
    reset = 1'b1; scl = 1'b1; sdaDrv = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset oe", sda_oe, 1'b0);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset dv", data_valid, 1'b0);
    checkOutput("reset out", outBus, 40'h0);
    reset = 1'b0;
    waitQ();

    txQ = '{8'h24, 8'h10, 8'h20, 8'h05, 8'h02, 8'h03};
    applyStimulus(1); verifyPacket("valid", 1);

    loadTx(8'h26, 5, 8'h00, 1);
    applyStimulus(1); verifyPacket("wrongaddr", 1);

    loadTx(8'h24, 3, 8'h00, 1);
    applyStimulus(1); verifyPacket("short", 1);

    loadTx(8'h24, 6, 8'h00, 1);
    applyStimulus(1); verifyPacket("overflow", 1);

    loadTx(8'h24, 2, 8'h00, 1);
    applyStimulus(0); verifyPacket("rstart1", 0);
    loadTx(8'h24, 5, 8'hA1, 0);
    applyStimulus(1); verifyPacket("rstart2", 1);
    checkOutput("rstart value", outBus, 40'hA1A2A3A4A5);

    // Reset in the middle of a packet: everything after it is ignored.
    ackQ.delete();
    dvBefore = dvCount;
    busStart();
    busWrite(8'h24, ack); ackQ.push_back(ack);
    for (int i = 0; i < 3; i++) begin
      busWrite(8'(8'h30 + i), ack); ackQ.push_back(ack);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    expBus = '0;
    for (int i = 0; i < 2; i++) begin
      busWrite(8'(8'h40 + i), ack); ackQ.push_back(ack);
    end
    busStop();
    waitQ();
    checkOutput("midreset acks", {ackQ[0], ackQ[1], ackQ[2], ackQ[3], ackQ[4], ackQ[5]},
                6'b111100);
    checkOutput("midreset dv", dvCount - dvBefore, 0);
    checkOutput("midreset out", outBus, 40'h0);
    checkOutput("midreset busy", busy, 1'b0);

    loadTx(8'h24, 5, 8'h00, 1);
    applyStimulus(1); verifyPacket("afterreset", 1);

    for (int p = 0; p < 8; p++) begin
      case ($urandom_range(0, 3))
        0, 1: a = 8'h24;
        2:    a = 8'h25;
        default: a = 8'($urandom);
      endcase
      loadTx(a, $urandom_range(0, 7), 8'h00, 1);
      if ($urandom_range(0, 1) == 1) begin
        txQ = txQ[0:0];
        loadTx(8'h24, 5, 8'h00, 1);
      end
      applyStimulus(1);
      verifyPacket($sformatf("rand%0d", p), 1);
    end

    checkOutput("stability", stabilityErrors, 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/i2c_ball_slave.md
I2C_BALL_SLAVE -- requirements
Module: i2c_ball_slave

Interface
REQ-001 The parameter list SHALL be: SLAVE_ADDR, 7'h12, 7-bit I2C address the block answers to.
REQ-002 The parameter list SHALL also include: NUM_BYTES, 5, data bytes per ball packet (fixed at 5).
REQ-003 The ports SHALL be: clk  input  1  system clock; only clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 scl  input  1  I2C clock from master; asynchronous to clk.
REQ-006 sda_i  input  1  I2C data line as sensed; asynchronous to clk.
REQ-007 sda_oe  output  1  1 = drive SDA low (open-drain); 0 = release.
REQ-008 y_pos0, y_pos1, y_vel, gravity, ball_speed  output  8 each  last committed packet bytes 0..4, in receive order.
REQ-009 data_valid  output  1  one-clk pulse when a new packet commits.
REQ-010 busy  output  1  high from START until return to IDLE.

Function
REQ-011 scl and sda_i SHALL each pass through a 2-flop synchronizer. Edge detection SHALL run on the synchronized values.
REQ-012 START SHALL be detected as a synchronized SDA fall while synchronized SCL is high; STOP SHALL be detected as an SDA rise while SCL is high.
REQ-013 States SHALL be IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, WAIT_STOP.
REQ-014 START in any state, including a repeated START mid-packet, SHALL go to ADDR, clear the bit count and byte count, and discard the shadow bytes.
REQ-015 ADDR and DATA SHALL shift in sda on each SCL rising edge, MSB first. After the 8th bit they SHALL wait for the next SCL falling edge.
REQ-016 Address byte: if byte[7:1]==SLAVE_ADDR and R/W==0, assert sda_oe on that SCL falling edge and go to ADDR_ACK. Otherwise, keep sda_oe=0 and go to WAIT_STOP.
REQ-017 In ADDR_ACK and DATA_ACK, sda_oe SHALL be held through the 9th SCL pulse and released on the 9th SCL falling edge. The next state is DATA.
REQ-018 Data byte n (n=0..4) SHALL be stored to shadow[n] and ACKed (DATA_ACK), then the byte count SHALL increment.
REQ-019 A 6th data byte SHALL NOT be ACKed. It SHALL set an overflow flag, and the state SHALL go to WAIT_STOP.
REQ-020 STOP in DATA or DATA_ACK with byte count==5 and no overflow SHALL copy all 5 shadow bytes to the outputs in the same clk and pulse data_valid for exactly one clk. The state SHALL go to IDLE.
REQ-021 STOP with byte count≠5, with overflow, or in ADDR/ADDR_ACK/WAIT_STOP SHALL go to IDLE. Outputs SHALL be unchanged and there SHALL be no data_valid pulse.
REQ-022 Latency: data_valid and the updated outputs SHALL appear 1 clk after the STOP is detected at the synchronizer output, i.e. ≤4 clk after the raw SDA rise.
REQ-023 Outputs SHALL change only on a commit. A partial packet SHALL never be visible on the outputs.
REQ-024 sda_oe SHALL be 0 in IDLE, ADDR, DATA and WAIT_STOP.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 A START and a STOP detected in the same clk are impossible after synchronization. If both flags are seen, START SHALL take priority.

Reset
REQ-027 While reset=1 on a clk edge, all state SHALL go to IDLE.
REQ-028 On reset, sda_oe=0, data_valid=0, busy=0, all five data outputs=8'h00, shadow bytes and counters=0, and the synchronizer flops=1 (idle bus).
REQ-029 Reset asserted mid-transaction SHALL abort it with no commit. After reset release, the block SHALL ignore bus activity until the next START.

Verification
REQ-030 Valid packet: START, 0x24 (addr 0x12, W), bytes 0x10 0x20 0x05 0x02 0x03, STOP -> 6 ACKs; y_pos0=0x10, y_pos1=0x20, y_vel=0x05, gravity=0x02, ball_speed=0x03; exactly one data_valid pulse.
REQ-031 Wrong address: START, 0x26, 5 bytes, STOP -> sda_oe never asserted; outputs keep their prior values; no data_valid.
REQ-032 Short packet: START, 0x24, 3 bytes, STOP -> 3 data ACKs; no commit; outputs unchanged.
REQ-033 Overflow: START, 0x24, 6 bytes, STOP -> 5 data ACKs and the 6th byte NACKed; no commit.
REQ-034 Repeated START: START, 0x24, 2 bytes, START, 0x24, 0xA1..0xA5, STOP -> outputs A1..A5; one data_valid pulse.
REQ-035 Reset mid-packet: reset pulse after the 3rd byte, then the bus continues to STOP -> outputs all 0x00; no data_valid; the next full packet commits normally.
